// File: rtl/fetch_queue_stage_pkg.sv
// Shared types and exception codes for the multi-outstanding instruction fetch stage.
// Codes mirror the core-wide exception code table.
package fetch_queue_stage_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // killed sits in bit 0 so the generic FIFO can set it on every stored entry
    typedef struct packed {
        logic [31:0] pc;
        logic        exc;
        logic        killed;
    } pend_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } ibuf_t;

endpackage

// File: rtl/fetch_queue_stage_fifo.sv
// Single-clock FIFO with flush; optionally sets bit 0 of every stored entry on kill.
// head is combinational from storage and only meaningful while count is non-zero.
module sync_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int KILL_EN = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     kill,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= ptr_inc(r_wptr);
            if (pop)  r_rptr <= ptr_inc(r_rptr);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    // The kill loop comes after the push write so an entry written this cycle is also marked
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wptr] <= push_data;
        if (KILL_EN != 0 && kill) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i][0] <= 1'b1;
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rptr];

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage with OUTSTANDING in-flight bus requests and a BUF_DEPTH instruction buffer.
// Misaligned PCs become ordered ADEL exceptions; cancel flushes the buffer and kills in-flight requests.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int BUF_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    output logic        ready_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] badvaddr_o,
    input  logic        cancel_i,
    output logic        wait_data
);
    localparam int PCW = $clog2(OUTSTANDING) + 1;
    localparam int BCW = $clog2(BUF_DEPTH) + 1;

    logic [PCW-1:0] w_pend_cnt;
    logic [BCW-1:0] w_buf_cnt;
    pend_t          w_pend_head;
    pend_t          w_pend_in;
    ibuf_t          w_buf_head;
    ibuf_t          w_buf_in;
    logic [PCW-1:0] r_data_pend;
    logic [PCW-1:0] r_exc_pend;

    logic w_room, w_aligned, w_take, w_push;
    logic w_pend_vld, w_exc_ret, w_data_ret, w_pend_pop;
    logic w_buf_push, w_buf_pop;

    always_comb begin
        // Credit covers pending entries so every response has a buffer slot waiting for it
        w_room    = (int'(w_pend_cnt) + int'(w_buf_cnt) < BUF_DEPTH) &&
                    (int'(w_pend_cnt) < OUTSTANDING);
        w_aligned = (pc_i[1:0] == 2'b00);
        w_take    = valid_i && w_room && !cancel_i;
        // Hold bus issue while an exception is queued: a response must never arrive with an
        // exception entry at the pending head, or it would have no entry to retire against.
        inst_req  = w_take && w_aligned && (r_exc_pend == '0);
        w_push    = (inst_req && inst_addr_ok) || (w_take && !w_aligned);
        w_pend_in = '{pc: pc_i, exc: !w_aligned, killed: 1'b0};

        w_pend_vld = (w_pend_cnt != '0);
        w_exc_ret  = w_pend_vld && w_pend_head.exc;
        w_data_ret = w_pend_vld && !w_pend_head.exc && inst_data_ok;
        w_pend_pop = w_exc_ret || w_data_ret;
        w_buf_push = w_pend_pop && !w_pend_head.killed && !cancel_i;
        w_buf_in   = '{pc:   w_pend_head.pc,
                       inst: w_exc_ret ? 32'h0 : inst_rdata,
                       exc:  w_exc_ret};

        w_buf_pop  = valid_o && ready_i;
    end

    assign inst_addr  = pc_i;
    assign ready_o    = w_push;
    assign valid_o    = (w_buf_cnt != '0);
    assign pc_o       = valid_o ? w_buf_head.pc : 32'h0;
    assign inst_o     = valid_o ? w_buf_head.inst : 32'h0;
    assign exc_o      = valid_o && w_buf_head.exc;
    assign exccode_o  = exc_o ? EXC_ADEL : 5'h00;
    assign badvaddr_o = exc_o ? w_buf_head.pc : 32'h0;
    assign wait_data  = (r_data_pend != '0);

    // Killed entries still count here: their responses have not drained yet
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_pend <= '0;
            r_exc_pend  <= '0;
        end else begin
            r_data_pend <= r_data_pend + PCW'(w_push && w_aligned) - PCW'(w_data_ret);
            r_exc_pend  <= r_exc_pend + PCW'(w_push && !w_aligned) - PCW'(w_exc_ret);
        end
    end

    sync_fifo #(
        .WIDTH   ($bits(pend_t)),
        .DEPTH   (OUTSTANDING),
        .KILL_EN (1)
    ) u_pend (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_pend_in),
        .pop       (w_pend_pop),
        .flush     (1'b0),
        .kill      (cancel_i),
        .count     (w_pend_cnt),
        .head      (w_pend_head)
    );

    sync_fifo #(
        .WIDTH   ($bits(ibuf_t)),
        .DEPTH   (BUF_DEPTH),
        .KILL_EN (0)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .push      (w_buf_push),
        .push_data (w_buf_in),
        .pop       (w_buf_pop),
        .flush     (cancel_i),
        .kill      (1'b0),
        .count     (w_buf_cnt),
        .head      (w_buf_head)
    );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: in-order bus model with programmable latency and a
// scoreboard of expected decode beats, plus a vector table and hand-written corner sequences.
module tb_fetch_queue_stage;
    import fetch_queue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        exc_o;
    logic [4:0]  exccode_o;
    logic [31:0] badvaddr_o;
    logic        cancel_i;
    logic        wait_data;

    always #5 clk = ~clk;

    fetch_queue_stage #(.OUTSTANDING(4), .BUF_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .valid_i(valid_i), .pc_i(pc_i), .ready_o(ready_o),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .inst_o(inst_o),
        .exc_o(exc_o), .exccode_o(exccode_o), .badvaddr_o(badvaddr_o),
        .cancel_i(cancel_i), .wait_data(wait_data)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic exc; } exp_t;
    typedef struct { logic [31:0] addr; int due; } bus_t;
    typedef struct { logic [31:0] pc; int lat; logic exp_req; logic exp_exc; int exp_delay; } vec_t;

    exp_t        sb[$];
    bus_t        bq[$];
    int          beat_cyc[$];
    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 2;
    int          acc_cyc = 0;
    logic        s_req, s_rdy, s_dok, s_exc;
    logic [31:0] s_addr;

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] val);
        checks++;
        errs++;
        $display("FAIL %s: bound expired or unexpected event, value %h", name, val);
    endtask

    // One clock: drive bus response, sample just after inputs settle, then advance
    task automatic tick();
        exp_t e;
        logic mis;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        if (bq.size() != 0) begin
            if (bq[0].due <= cyc) begin
                inst_data_ok = 1'b1;
                inst_rdata   = exp_inst(bq[0].addr);
            end
        end
        #1;
        s_req  = inst_req;
        s_rdy  = ready_o;
        s_dok  = inst_data_ok;
        s_addr = inst_addr;
        if (inst_req) chk("req_aligned", 32'(inst_addr[1:0]), 32'h0);
        if (valid_o && ready_i && !reset) begin
            beat_cyc.push_back(cyc);
            s_exc = exc_o;
            if (sb.size() == 0) fail("unexpected_beat", pc_o);
            else begin
                e = sb.pop_front();
                chk("beat_pc", pc_o, e.pc);
                chk("beat_inst", inst_o, e.inst);
                chk("beat_exc", 32'(exc_o), 32'(e.exc));
                chk("beat_code", 32'(exccode_o), e.exc ? 32'(EXC_ADEL) : 32'h0);
                chk("beat_badv", badvaddr_o, e.exc ? e.pc : 32'h0);
            end
        end
        if (cancel_i) begin
            chk("push_on_cancel", 32'(ready_o), 32'h0);
            sb.delete();
        end
        if (ready_o) begin
            mis = (pc_i[1:0] != 2'b00);
            sb.push_back('{pc_i, mis ? 32'h0 : exp_inst(pc_i), mis});
            acc_cyc = cyc;
        end
        @(posedge clk);
        if (s_dok) void'(bq.pop_front());
        if (s_req && inst_addr_ok) bq.push_back('{s_addr, cyc + lat});
        cyc++;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] pc, output logic req_at_acc);
        valid_i    = 1'b1;
        pc_i       = pc;
        req_at_acc = 1'b0;
        s_rdy      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_rdy) begin
                req_at_acc = s_req;
                break;
            end
        end
        if (!s_rdy) fail("fetch_timeout", pc);
        valid_i = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 60 && beat_cyc.size() < n; i++) tick();
        if (beat_cyc.size() < n) fail("beat_timeout", 32'(beat_cyc.size()));
    endtask

    // Responses must only arrive for a pending fetch
    always @(posedge clk) begin
        if (!reset && inst_data_ok) assert (wait_data) else $error("data_ok with no pending fetch");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        logic r;
        int   k;

        vt[0] = '{32'h0000_0100, 1, 1'b1, 1'b0, 2};
        vt[1] = '{32'h0000_0104, 3, 1'b1, 1'b0, 4};
        vt[2] = '{32'h0000_0201, 1, 1'b0, 1'b1, 2};
        vt[3] = '{32'h0000_0202, 2, 1'b0, 1'b1, 2};
        vt[4] = '{32'h0000_0203, 1, 1'b0, 1'b1, 2};
        vt[5] = '{32'hFFFF_FFFC, 2, 1'b1, 1'b0, 3};
        vt[6] = '{32'h0000_0000, 1, 1'b1, 1'b0, 2};

        reset = 1'b1; valid_i = 1'b0; pc_i = 32'h0; ready_i = 1'b0; cancel_i = 1'b0;
        inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        @(negedge clk);
        drain(2);
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_exc", 32'(exc_o), 32'h0);
        chk("rst_code", 32'(exccode_o), 32'h0);
        chk("rst_badv", badvaddr_o, 32'h0);
        chk("rst_wait", 32'(wait_data), 32'h0);
        chk("rst_req", 32'(inst_req), 32'h0);
        @(negedge clk);

        // Single-fetch vectors: request/no-request, exception flag and accept-to-valid latency
        ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            lat = vt[i].lat;
            beat_cyc.delete();
            fetch(vt[i].pc, r);
            chk("vec_req", 32'(r), 32'(vt[i].exp_req));
            wait_beats(1);
            if (beat_cyc.size() > 0) begin
                chk("vec_delay", 32'(beat_cyc[0] - acc_cyc), 32'(vt[i].exp_delay));
                chk("vec_exc", 32'(s_exc), 32'(vt[i].exp_exc));
            end
        end
        drain(2);

        // Streaming at latency 2: four beats on consecutive cycles
        lat = 2; beat_cyc.delete(); k = 0;
        valid_i = 1'b1; pc_i = 32'h1000;
        for (int i = 0; i < 30 && beat_cyc.size() < 4; i++) begin
            tick();
            if (s_rdy) begin
                k++;
                if (k < 4) pc_i = 32'h1000 + 32'(4 * k);
                else valid_i = 1'b0;
            end
        end
        valid_i = 1'b0;
        chk("stream_beats", 32'(beat_cyc.size()), 32'd4);
        for (int i = 1; i < 4 && i < beat_cyc.size(); i++)
            chk("stream_gap", 32'(beat_cyc[i] - beat_cyc[i-1]), 32'd1);
        drain(3);

        // Back-pressure: decode stalls for 10 cycles, credit caps acceptance at BUF_DEPTH
        ready_i = 1'b0; lat = 2; k = 0;
        valid_i = 1'b1; pc_i = 32'h3000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_rdy) begin
                k++;
                pc_i = 32'h3000 + 32'(4 * k);
            end
        end
        chk("bp_accepts", 32'(k), 32'd4);
        chk("bp_ready_held", 32'(s_rdy), 32'h0);
        chk("bp_head_pc", pc_o, 32'h3000);
        valid_i = 1'b0; ready_i = 1'b1; beat_cyc.delete();
        wait_beats(4);
        drain(3);
        chk("bp_beats", 32'(beat_cyc.size()), 32'd4);
        chk("bp_sb_empty", 32'(sb.size()), 32'h0);

        // Misaligned PC queued behind two outstanding fetches
        lat = 4; beat_cyc.delete();
        fetch(32'h1000, r);
        fetch(32'h1004, r);
        fetch(32'h1002, r);
        chk("mis_no_req", 32'(r), 32'h0);
        wait_beats(3);
        drain(2);
        chk("mis_beats", 32'(beat_cyc.size()), 32'd3);
        chk("mis_last_exc", 32'(s_exc), 32'h1);
        chk("mis_sb_empty", 32'(sb.size()), 32'h0);

        // Cancel with two buffered and two in flight, then a fresh fetch
        ready_i = 1'b0; lat = 1; beat_cyc.delete();
        fetch(32'h4000, r);
        fetch(32'h4004, r);
        drain(3);
        chk("cx_buffered", 32'(valid_o), 32'h1);
        lat = 8;
        fetch(32'h4008, r);
        fetch(32'h400C, r);
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        chk("cx_valid_drop", 32'(valid_o), 32'h0);
        chk("cx_wait_data", 32'(wait_data), 32'h1);
        ready_i = 1'b1; lat = 1;
        fetch(32'h2000, r);
        chk("cx_new_req", 32'(r), 32'h1);
        wait_beats(1);
        drain(4);
        chk("cx_beats", 32'(beat_cyc.size()), 32'd1);
        chk("cx_sb_empty", 32'(sb.size()), 32'h0);
        chk("cx_wait_clear", 32'(wait_data), 32'h0);

        // Cancel in the same cycle as a data return and a new PC
        lat = 2; beat_cyc.delete();
        fetch(32'h5000, r);
        tick();
        cancel_i = 1'b1; valid_i = 1'b1; pc_i = 32'h5004;
        tick();
        chk("sc_dok", 32'(s_dok), 32'h1);
        chk("sc_req", 32'(s_req), 32'h0);
        chk("sc_rdy", 32'(s_rdy), 32'h0);
        cancel_i = 1'b0; valid_i = 1'b0;
        chk("sc_valid_next", 32'(valid_o), 32'h0);
        drain(4);
        chk("sc_no_beat", 32'(beat_cyc.size()), 32'h0);
        chk("sc_wait_clear", 32'(wait_data), 32'h0);

        // Reset with the pending queue full
        ready_i = 1'b0; lat = 6;
        fetch(32'h6000, r);
        fetch(32'h6004, r);
        fetch(32'h6008, r);
        fetch(32'h600C, r);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete(); bq.delete();
        chk("mr_valid", 32'(valid_o), 32'h0);
        chk("mr_pc", pc_o, 32'h0);
        chk("mr_badv", badvaddr_o, 32'h0);
        chk("mr_wait", 32'(wait_data), 32'h0);
        valid_i = 1'b1; pc_i = 32'h7000; ready_i = 1'b1;
        #1;
        chk("mr_credit_free", 32'(ready_o), 32'h1);
        @(negedge clk);
        lat = 1; beat_cyc.delete();
        fetch(32'h7000, r);
        wait_beats(1);
        drain(2);
        chk("mr_sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
